// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: comparator cascade word and
// the serial compare controller state encoding.
package calc_pkg;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_cascade_t;

  localparam cmp_cascade_t CASCADE_EQ = '{lt: 1'b0, gt: 1'b0, eq: 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_compare.sv
// Combinational 4-bit cascadable magnitude comparator stage.
// A differing nibble decides the result; an equal nibble forwards the cascade.
module nibble_compare
  import calc_pkg::*;
(
  input  logic [3:0]   a,
  input  logic [3:0]   b,
  input  cmp_cascade_t cin,
  output cmp_cascade_t cout
);

  always_comb begin
    cout = cin;
    if (a > b) begin
      cout = '{lt: 1'b0, gt: 1'b1, eq: 1'b0};
    end else if (a < b) begin
      cout = '{lt: 1'b1, gt: 1'b0, eq: 1'b0};
    end
  end

endmodule

// File: rtl/serial_magnitude_compare.sv
// Wide magnitude compare using one shared nibble stage, LS nibble first,
// with the running cascade registered between nibbles.
module serial_magnitude_compare
  import calc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 a_lt_b,
  output logic                 a_gt_b,
  output logic                 a_eq_b
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             signed_reg;
  cmp_cascade_t     cas_reg;
  cmp_cascade_t     res_reg;
  cmp_cascade_t     stage_out;

  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];
  logic [3:0] a_sel;
  logic [3:0] b_sel;
  logic       last_nib;
  logic       accept;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  assign last_nib = (idx_reg == IDX_W'(NIBBLES - 1));
  assign accept   = start && (state_reg != RUN);

  // Signed compare: flipping the sign bits turns two's complement into
  // offset binary, which then orders correctly as unsigned.
  always_comb begin
    a_sel = a_nib[idx_reg];
    b_sel = b_nib[idx_reg];
    if (signed_reg && last_nib) begin
      a_sel[3] = ~a_sel[3];
      b_sel[3] = ~b_sel[3];
    end
  end

  nibble_compare u_stage (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cas_reg),
    .cout (stage_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      cas_reg    <= CASCADE_EQ;
      res_reg    <= CASCADE_EQ;
    end else if (accept) begin
      idx_reg    <= '0;
      a_reg      <= a;
      b_reg      <= b;
      signed_reg <= signed_mode;
      cas_reg    <= CASCADE_EQ;
    end else if (state_reg == RUN) begin
      cas_reg <= stage_out;
      if (last_nib) begin
        res_reg <= stage_out;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign a_lt_b = res_reg.lt;
  assign a_gt_b = res_reg.gt;
  assign a_eq_b = res_reg.eq;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Self-checking bench: directed cases plus a randomized sweep against a
// plain-arithmetic compare model.
module tb_serial_magnitude_compare;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic         a_lt_b;
  logic         a_gt_b;
  logic         a_eq_b;

  int n_cmp = 0;
  int n_err = 0;
  bit onehot_en = 1'b0;

  serial_magnitude_compare #(.NIBBLES(NIBBLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_lt_b      (a_lt_b),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {lt,gt,eq} from whole-operand arithmetic.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    if (sm) begin
      if ($signed(x) < $signed(y)) return 3'b100;
      if ($signed(x) > $signed(y)) return 3'b010;
      return 3'b001;
    end
    if (x < y) return 3'b100;
    if (x > y) return 3'b010;
    return 3'b001;
  endfunction

  always @(negedge clk) begin
    if (onehot_en && rst_n)
      check("onehot", 32'($countones({a_lt_b, a_gt_b, a_eq_b})), 32'd1);
  end

  // Counts busy cycles until done is seen, with a bounded cycle budget.
  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int c = 0; c < NIBBLES + 4; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic sm);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb2; signed_mode = sm;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic sm);
    int bc;
    bit seen;
    logic [2:0] exp;
    exp = ref_cmp(ta, tb2, sm);
    accept_op(ta, tb2, sm);
    wait_done(bc, seen);
    check("busy_cycles", 32'(bc), 32'(NIBBLES));
    check("done_seen", 32'(seen), 32'd1);
    check("result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, {29'd0, exp});
    $display("cmp a=%h b=%h s=%0d -> lt=%0d gt=%0d eq=%0d (exp %b)",
             ta, tb2, sm, a_lt_b, a_gt_b, a_eq_b, exp);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check("result_hold", {29'd0, a_lt_b, a_gt_b, a_eq_b}, {29'd0, exp});
  endtask

  initial begin
    int bc;
    int ndone;
    bit seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    onehot_en = 1'b1;

    // Directed cases
    run_cmp(16'h1234, 16'h1234, 1'b0);
    run_cmp(16'h2001, 16'h1FFF, 1'b0);
    run_cmp(16'h1FFF, 16'h2001, 1'b0);
    run_cmp(16'h8000, 16'h0001, 1'b1);
    run_cmp(16'h8000, 16'h0001, 1'b0);
    run_cmp(16'hFFFF, 16'hFFFE, 1'b1);
    run_cmp(16'h7FFF, 16'h8000, 1'b1);

    // Start while busy is ignored: only one done, first result kept
    accept_op(16'h2001, 16'h1FFF, 1'b0);
    @(negedge clk);
    start = 1'b1; a = '0; b = '0; signed_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 2 * NIBBLES + 4; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignored_start_dones", 32'(ndone), 32'd1);
    check("ignored_start_result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b010);
    $display("busy-start: dones=%0d lt=%0d gt=%0d eq=%0d", ndone, a_lt_b, a_gt_b, a_eq_b);

    // Start held in the DONE cycle is accepted back-to-back
    accept_op(16'h0010, 16'h0001, 1'b0);
    wait_done(bc, seen);
    check("b2b_first_done", 32'(seen), 32'd1);
    check("b2b_first_result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b010);
    start = 1'b1; a = 16'h1FFF; b = 16'h2001; signed_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(bc, seen);
    check("b2b_busy_cycles", 32'(bc), 32'(NIBBLES));
    check("b2b_second_done", 32'(seen), 32'd1);
    check("b2b_second_result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b100);
    $display("back-to-back: busy=%0d lt=%0d gt=%0d eq=%0d", bc, a_lt_b, a_gt_b, a_eq_b);
    @(negedge clk);

    // Reset in RUN at nibble index 2 aborts without a done pulse
    run_cmp(16'h2001, 16'h1FFF, 1'b0);
    accept_op(16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", {29'd0, a_lt_b, a_gt_b, a_eq_b}, 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(bc, seen);
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_no_busy", 32'(bc), 32'd0);
    $display("abort: busy=%0d done_seen=%0d", bc, seen);
    run_cmp(16'h0001, 16'h0002, 1'b0);

    // Randomized sweep, both modes, biased towards near-equal operands
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, 1'($urandom));
    end

    onehot_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
